// File: rtl/lcd_spi_writer_if.sv
// Word hand-off between an LCD word generator (master) and lcd_spi_writer (slave).
// data[8] is D/C (0 command, 1 data); data[7:0] is the byte to send.
interface lcd_spi_writer_if;
    logic       en_write;
    logic [8:0] data;
    logic       wr_done;

    modport master (output en_write, output data, input wr_done);
    modport slave  (input en_write, input data, output wr_done);
endinterface

// File: rtl/lcd_spi_writer.sv
// Serialises 9-bit LCD words onto a 4-wire SPI link (mode 0, MSB first) and pulses wr_done per word.
// Optional macro LCD_SPI_CS_KEEP_EN: keep lcd_cs low across back-to-back words while en_write stays high.
module lcd_spi_writer #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    lcd_spi_writer_if.slave bus,
    output logic            lcd_cs,
    output logic            lcd_dc,
    output logic            lcd_sclk,
    output logic            lcd_mosi
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    localparam logic [3:0] IDLE  = 4'b0001;
    localparam logic [3:0] SHIFT = 4'b0010;
    localparam logic [3:0] DONE  = 4'b0100;
    localparam logic [3:0] GAP   = 4'b1000;

    logic [3:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [6:0]       shreg;
    logic             wr_done;

    assign bus.wr_done = wr_done;

    // Bit 7 goes straight to lcd_mosi at the latch edge; shreg only holds the bits still to come.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= 3'd0;
            gap_cnt  <= '0;
            shreg    <= 7'd0;
            wr_done  <= 1'b0;
            lcd_cs   <= 1'b1;
            lcd_dc   <= 1'b0;
            lcd_sclk <= 1'b0;
            lcd_mosi <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en_write) begin
                        shreg    <= bus.data[6:0];
                        lcd_mosi <= bus.data[7];
                        lcd_dc   <= bus.data[8];
                        lcd_cs   <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= 3'd0;
                        state    <= SHIFT;
                    end else begin
                        lcd_cs <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!lcd_sclk) begin
                            lcd_sclk <= 1'b1;
                        end else begin
                            // Falling SCLK edge: the only place lcd_mosi may change.
                            lcd_sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                wr_done <= 1'b1;
                                state   <= DONE;
`ifndef LCD_SPI_CS_KEEP_EN
                                lcd_cs  <= 1'b1;
`endif
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                lcd_mosi <= shreg[6];
                                shreg    <= {shreg[5:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DONE: begin
                    wr_done  <= 1'b0;
                    lcd_sclk <= 1'b0;
                    gap_cnt  <= '0;
                    state    <= GAP;
`ifndef LCD_SPI_CS_KEEP_EN
                    lcd_cs   <= 1'b1;
`endif
                end
                GAP: begin
                    // Upstream uses this window to present its next word.
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    wr_done  <= 1'b0;
                    lcd_sclk <= 1'b0;
                    lcd_cs   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Self-checking bench for lcd_spi_writer (CLK_DIV=2, GAP_CYCLES=4): directed words, a streamed
// frame table, mid-word en_write drop, mid-word reset, and CS behaviour with or without LCD_SPI_CS_KEEP_EN.
module tb_lcd_spi_writer;

    typedef struct {
        logic [8:0] data;
        logic [7:0] exp_byte;
        logic       exp_dc;
    } vec_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic lcd_cs, lcd_dc, lcd_sclk, lcd_mosi;

    lcd_spi_writer_if bus ();

    lcd_spi_writer #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .lcd_cs    (lcd_cs),
        .lcd_dc    (lcd_dc),
        .lcd_sclk  (lcd_sclk),
        .lcd_mosi  (lcd_mosi)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passes = 0;

    int         cyc         = 0;
    int         rise_cnt    = 0;
    int         toggle_err  = 0;
    int         width_err   = 0;
    int         cs_high_cnt = 0;
    int         latch_cyc   = 0;
    logic [7:0] rx          = 8'd0;
    logic       prev_sclk   = 1'b0;
    logic       prev_mosi   = 1'b0;
    logic       prev_cs     = 1'b1;
    logic       prev_done   = 1'b0;
    int         done_cyc[$];
    logic [7:0] done_byte[$];
    logic       done_dc[$];
    int         done_rises[$];

    always @(posedge sys_clk) cyc++;

    // Line monitor: rebuilds each byte from lcd_mosi at SCLK rising edges and logs every wr_done.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            rise_cnt = 0;
            rx       = 8'd0;
        end else begin
            if (lcd_sclk && !prev_sclk) begin
                rise_cnt++;
                rx = {rx[6:0], lcd_mosi};
            end
            if (lcd_sclk && prev_sclk && (lcd_mosi != prev_mosi)) toggle_err++;
            if (!lcd_cs && prev_cs) latch_cyc = cyc;
            if (bus.wr_done) begin
                if (prev_done) width_err++;
                done_cyc.push_back(cyc);
                done_byte.push_back(rx);
                done_dc.push_back(lcd_dc);
                done_rises.push_back(rise_cnt);
                rise_cnt = 0;
            end
        end
        if (lcd_cs) cs_high_cnt++;
        prev_sclk = lcd_sclk;
        prev_mosi = lcd_mosi;
        prev_cs   = lcd_cs;
        prev_done = bus.wr_done;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [8:0] d);
        bus.en_write = 1'b1;
        bus.data     = d;
    endtask

    task automatic waitDone(input int target, input int budget);
        int n = 0;
        while (done_cyc.size() < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cyc.size() < target) checkOutput("wr_done timeout", done_cyc.size(), target);
    endtask

    task automatic waitLatch(input int budget);
        int n = 0;
        while (lcd_cs !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (lcd_cs !== 1'b0) checkOutput("latch timeout", 1, 0);
    endtask

    task automatic sendWord(input string tag, input logic [8:0] d, input logic [7:0] exp_byte,
                            input logic exp_dc);
        int b = done_cyc.size();
        applyStimulus(d);
        waitDone(b + 1, 100);
        bus.en_write = 1'b0;
        if (done_cyc.size() > b) begin
            checkOutput({tag, " byte"}, done_byte[b], exp_byte);
            checkOutput({tag, " dc"}, done_dc[b], exp_dc);
            checkOutput({tag, " sclk rises"}, done_rises[b], 8);
            checkOutput({tag, " latency"}, done_cyc[b] - latch_cyc, 32);
        end
`ifndef LCD_SPI_CS_KEEP_EN
        checkOutput({tag, " cs in DONE"}, lcd_cs, 1);
`endif
        tick();
        checkOutput({tag, " wr_done width"}, bus.wr_done, 0);
        repeat (8) tick();
        checkOutput({tag, " cs idle"}, lcd_cs, 1);
    endtask

    initial begin
        vec_t stream_vecs[11];
        int   b;
        int   snap;
        int   cs_snap[3];

        stream_vecs[0]  = '{9'h02A, 8'h2A, 1'b0};
        stream_vecs[1]  = '{9'h100, 8'h00, 1'b1};
        stream_vecs[2]  = '{9'h100, 8'h00, 1'b1};
        stream_vecs[3]  = '{9'h100, 8'h00, 1'b1};
        stream_vecs[4]  = '{9'h1EF, 8'hEF, 1'b1};
        stream_vecs[5]  = '{9'h02B, 8'h2B, 1'b0};
        stream_vecs[6]  = '{9'h100, 8'h00, 1'b1};
        stream_vecs[7]  = '{9'h100, 8'h00, 1'b1};
        stream_vecs[8]  = '{9'h101, 8'h01, 1'b1};
        stream_vecs[9]  = '{9'h13F, 8'h3F, 1'b1};
        stream_vecs[10] = '{9'h02C, 8'h2C, 1'b0};

        bus.en_write = 1'b0;
        bus.data     = 9'h000;
        repeat (4) tick();
        checkOutput("reset wr_done", bus.wr_done, 0);
        checkOutput("reset cs", lcd_cs, 1);
        checkOutput("reset dc", lcd_dc, 0);
        checkOutput("reset sclk", lcd_sclk, 0);
        checkOutput("reset mosi", lcd_mosi, 0);
        sys_rst_n = 1'b1;
        repeat (3) tick();

        $display("[TB] single words 0x02A and 0x1EF");
        sendWord("w02A", 9'h02A, 8'h2A, 1'b0);
        sendWord("w1EF", 9'h1EF, 8'hEF, 1'b1);
        checkOutput("mosi stable while sclk high", toggle_err, 0);

        $display("[TB] streamed 11-word sequence");
        b = done_cyc.size();
        applyStimulus(stream_vecs[0].data);
        for (int i = 0; i < 11; i++) begin
            waitDone(b + i + 1, 100);
            if (i == 10) begin
                bus.en_write = 1'b0;
            end else begin
                tick();
                tick();
                bus.data = stream_vecs[i + 1].data;
            end
        end
        checkOutput("stream pulse count", done_cyc.size() - b, 11);
        for (int i = 0; i < 11; i++) begin
            if (b + i < done_cyc.size()) begin
                checkOutput($sformatf("stream %0d byte", i), done_byte[b + i], stream_vecs[i].exp_byte);
                checkOutput($sformatf("stream %0d dc", i), done_dc[b + i], stream_vecs[i].exp_dc);
                if (i > 0)
                    checkOutput($sformatf("stream %0d period", i),
                                done_cyc[b + i] - done_cyc[b + i - 1], 38);
            end
        end
        repeat (10) tick();

        $display("[TB] en_write dropped mid-word");
        b = done_cyc.size();
        applyStimulus(9'h0FF);
        waitLatch(20);
        repeat (5) tick();
        bus.en_write = 1'b0;
        waitDone(b + 1, 100);
        if (done_cyc.size() > b) begin
            checkOutput("drop byte", done_byte[b], 8'hFF);
            checkOutput("drop dc", done_dc[b], 0);
            checkOutput("drop sclk rises", done_rises[b], 8);
        end
        repeat (60) tick();
        checkOutput("drop single pulse", done_cyc.size() - b, 1);
        checkOutput("drop no extra sclk", rise_cnt, 0);
        checkOutput("drop cs idle", lcd_cs, 1);
        checkOutput("drop sclk idle", lcd_sclk, 0);

        $display("[TB] reset mid-word");
        b = done_cyc.size();
        applyStimulus(9'h155);
        waitLatch(20);
        repeat (9) tick();
        sys_rst_n    = 1'b0;
        bus.en_write = 1'b0;
        #1;
        checkOutput("abort cs", lcd_cs, 1);
        checkOutput("abort dc", lcd_dc, 0);
        checkOutput("abort sclk", lcd_sclk, 0);
        checkOutput("abort mosi", lcd_mosi, 0);
        checkOutput("abort wr_done", bus.wr_done, 0);
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (40) tick();
        checkOutput("abort no wr_done", done_cyc.size() - b, 0);
        sendWord("after reset", 9'h0C3, 8'hC3, 1'b0);

        $display("[TB] CS behaviour across three streamed words");
        b = done_cyc.size();
        applyStimulus(stream_vecs[0].data);
        waitLatch(20);
        snap = cs_high_cnt;
        for (int i = 0; i < 3; i++) begin
            waitDone(b + i + 1, 100);
            cs_snap[i] = cs_high_cnt;
            if (i == 2) begin
                bus.en_write = 1'b0;
            end else begin
                tick();
                tick();
                bus.data = stream_vecs[i + 1].data;
            end
        end
        repeat (3) tick();
`ifdef LCD_SPI_CS_KEEP_EN
        checkOutput("cs held low across stream", cs_high_cnt - snap, 0);
`else
        checkOutput("cs high between words 0-1", cs_snap[1] - cs_snap[0], 6);
        checkOutput("cs high between words 1-2", cs_snap[2] - cs_snap[1], 6);
        checkOutput("cs low during first word", cs_snap[0] - snap, 1);
`endif
        repeat (10) tick();
        checkOutput("cs released in idle", lcd_cs, 1);
        checkOutput("wr_done never wider than 1", width_err, 0);
        checkOutput("mosi never toggles with sclk high", toggle_err, 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
